// File: rtl/bus_arb_pkg.sv
// Shared types and parameter limits for the internal bus arbiter.
// Included by both the RTL and the bench.
package bus_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arbState_t;

    localparam int REQ_COUNT_MIN = 2;
    localparam int REQ_COUNT_MAX = 16;
    localparam int MAX_HOLD_MIN  = 1;
    localparam int MAX_HOLD_MAX  = 15;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit at or above ptr_i, wrapping around.
// Purely combinational.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    // Scan offsets from highest to lowest so the smallest offset from ptr_i wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int c;
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            if (req_i[c]) begin
                idx_o   = PW'(c);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/internal_bus_arbiter.sv
// One-hot grant arbiter for the wired-OR internal data bus.
// It uses round-robin fairness and caps how long one owner can keep the bus.
module internal_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int REQUESTER_COUNT = 4,
    parameter  int MAX_HOLD        = 4,
    localparam int IW              = $clog2(REQUESTER_COUNT),
    localparam int HCW             = $clog2(MAX_HOLD + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [REQUESTER_COUNT-1:0] req_i,
    input  logic [REQUESTER_COUNT-1:0] hold_i,
    output logic [REQUESTER_COUNT-1:0] grant_o,
    output logic                       grant_valid_o,
    output logic [IW-1:0]              grant_index_o,
    output logic                       cap_release_o,
    output arbState_t                  state_o
);

    arbState_t                  state_q;
    logic [REQUESTER_COUNT-1:0] grant_q;
    logic                       valid_q;
    logic [IW-1:0]              index_q;
    logic [IW-1:0]              ptr_q;
    logic [HCW-1:0]             hold_cnt_q;
    logic                       cap_q;

    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [IW-1:0] ptr_d;
    logic          owner_wants;
    logic          retain;
    logic          cap_hit;

    rr_pick #(.N(REQUESTER_COUNT)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // The owner has the lowest priority in pick after its grant.
    // A release therefore hands over to another requester first.
    // It re-grants the owner only when the owner is the sole requester.
    always_comb begin
        owner_wants = (state_q == OWNED) && req_i[index_q] && hold_i[index_q];
        retain      = owner_wants && (hold_cnt_q < HCW'(MAX_HOLD));
        cap_hit     = owner_wants && !retain;
        ptr_d       = (pick_idx == IW'(REQUESTER_COUNT - 1)) ? '0 : pick_idx + IW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            cap_q      <= 1'b0;
        end else begin
            cap_q <= cap_hit;
            if (retain) begin
                hold_cnt_q <= hold_cnt_q + HCW'(1);
            end else if (pick_found) begin
                state_q    <= OWNED;
                grant_q    <= {{(REQUESTER_COUNT-1){1'b0}}, 1'b1} << pick_idx;
                valid_q    <= 1'b1;
                index_q    <= pick_idx;
                ptr_q      <= ptr_d;
                hold_cnt_q <= HCW'(1);
            end else begin
                state_q    <= IDLE;
                grant_q    <= '0;
                valid_q    <= 1'b0;
                index_q    <= '0;
                hold_cnt_q <= '0;
            end
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign grant_index_o = index_q;
    assign cap_release_o = cap_q;
    assign state_o       = state_q;

endmodule
